// File: rtl/alu_issue_queue.sv
// Issue stage for the ALU pipeline: FIFO of packed instruction words, one issue per clock,
// with a shift-register scoreboard that holds back RAW-dependent words for HAZARD_WINDOW edges.
module alu_issue_queue #(
    parameter int DEPTH         = 8,
    parameter int HAZARD_WINDOW = 3
) (
    input  logic                     clk_1,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [23:0]              in_instr,
    input  logic                     flush,
    input  logic                     issue_en,
    output logic [3:0]               s1,
    output logic [3:0]               s2,
    output logic [3:0]               r_addr,
    output logic [3:0]               opr,
    output logic [7:0]               addr,
    output logic                     issue_valid,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int SB_N = (HAZARD_WINDOW > 1) ? HAZARD_WINDOW - 1 : 1;

    typedef struct packed {
        logic [3:0] opr;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] r_addr;
        logic [7:0] addr;
    } instr_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
    } sb_entry_t;

    instr_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    sb_entry_t sb [SB_N];

    instr_t head;
    logic   head_present;
    logic   hazard;
    logic   push;
    logic   pop;

    assign head         = mem[rd_ptr];
    assign head_present = (count != '0);
    assign in_ready     = (count < CW'(DEPTH));
    assign push         = in_valid && in_ready && !flush;
    assign pop          = issue_en && head_present && !hazard && !flush;
    assign stall        = issue_en && head_present && hazard;

    // A head that writes its own source is not blocked by itself: only older producers count.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < SB_N; i++) begin
            if (HAZARD_WINDOW > 1 && sb[i].valid &&
                (sb[i].rd == head.s1 || sb[i].rd == head.s2)) begin
                hazard = 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by count and the pointers,
    // so clearing it would only cost reset fan-out.
    always_ff @(posedge clk_1) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    // NOTE: every sequential update uses non-blocking assignment so all state samples
    // pre-edge values, e.g. the scoreboard shift reads the old neighbour entry.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < SB_N; i++) begin
                sb[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < SB_N; i++) begin
                sb[i] <= '0;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            // Scoreboard ages every edge; only an actual issue inserts a live producer.
            sb[0] <= '{valid: pop, rd: head.r_addr};
            for (int i = 1; i < SB_N; i++) begin
                sb[i] <= sb[i-1];
            end
        end
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            s1          <= '0;
            s2          <= '0;
            r_addr      <= '0;
            opr         <= '0;
            addr        <= '0;
            issue_valid <= 1'b0;
        end else begin
            issue_valid <= pop;
            if (pop) begin
                s1     <= head.s1;
                s2     <= head.s2;
                r_addr <= head.r_addr;
                opr    <= head.opr;
                addr   <= head.addr;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue (DEPTH=8, HAZARD_WINDOW=3) with hand-derived expectations.
module tb_alu_issue_queue;

    logic        clk_1 = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_instr;
    logic        flush;
    logic        issue_en;
    logic [3:0]  s1, s2, r_addr, opr;
    logic [7:0]  addr;
    logic        issue_valid;
    logic        stall;
    logic [3:0]  count;

    int checks   = 0;
    int failures = 0;

    alu_issue_queue #(.DEPTH(8), .HAZARD_WINDOW(3)) dut (
        .clk_1       (clk_1),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .flush       (flush),
        .issue_en    (issue_en),
        .s1          (s1),
        .s2          (s2),
        .r_addr      (r_addr),
        .opr         (opr),
        .addr        (addr),
        .issue_valid (issue_valid),
        .stall       (stall),
        .count       (count)
    );

    always #5 clk_1 = ~clk_1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issued fields reassembled in the packed input order for one-shot comparison.
    function automatic logic [23:0] fields();
        return {opr, s1, s2, r_addr, addr};
    endfunction

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    function automatic logic [23:0] w_word(input int i);
        return {4'(i), 4'hF, 4'hF, 4'(i), 8'(8'h40 + i)};
    endfunction

    function automatic logic [23:0] x_word(input int j);
        return {4'(j), 4'hF, 4'hF, 4'(j + 8), 8'(8'h80 + j)};
    endfunction

    localparam logic [23:0] A = 24'h035A7D;
    localparam logic [23:0] B = 24'h238C7E;
    localparam logic [23:0] C = 24'h1A5E7F;
    localparam logic [23:0] P = {4'h3, 4'hF, 4'hF, 4'h5, 8'h11};
    localparam logic [23:0] Z = {4'h7, 4'hF, 4'hF, 4'h9, 8'hEE};
    localparam logic [23:0] D = {4'h5, 4'h5, 4'h5, 4'h5, 8'h33};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xi;
        logic acc;
        logic [23:0] exp_w;

        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; issue_en = 1'b0;
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_issue_valid", 32'(issue_valid), 0);
        check("rst_fields", 32'(fields()), 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_stall", 32'(stall), 0);

        // Independent stream, then a RAW dependent on A (r_addr=10).
        in_valid = 1'b1; in_instr = A; issue_en = 1'b1;
        tick();
        check("ind_count_a", 32'(count), 1);
        check("ind_no_issue_yet", 32'(issue_valid), 0);
        in_instr = B;
        tick();
        check("ind_issue_a_valid", 32'(issue_valid), 1);
        check("ind_issue_a_fields", 32'(fields()), 32'(A));
        check("ind_stall_b", 32'(stall), 0);
        in_instr = C;
        tick();
        check("ind_issue_b_valid", 32'(issue_valid), 1);
        check("ind_issue_b_fields", 32'(fields()), 32'(B));
        check("raw_stall_set", 32'(stall), 1);
        in_valid = 1'b0;
        tick();
        check("raw_bubble", 32'(issue_valid), 0);
        check("raw_fields_hold", 32'(fields()), 32'(B));
        check("raw_count", 32'(count), 1);
        check("raw_stall_clear", 32'(stall), 0);
        tick();
        check("raw_issue_c_valid", 32'(issue_valid), 1);
        check("raw_issue_c_fields", 32'(fields()), 32'(C));
        check("raw_count_empty", 32'(count), 0);

        // Fill to full with issue disabled; the ninth word is dropped.
        issue_en = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_instr = w_word(i);
            tick();
        end
        check("full_count", 32'(count), 8);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_no_issue", 32'(issue_valid), 0);

        // Drain while pushing six more; order must survive pointer wrap.
        issue_en = 1'b1; xi = 0;
        for (int n = 0; n < 14; n++) begin
            in_valid = (xi < 6);
            in_instr = x_word(xi);
            acc = in_valid && in_ready;
            tick();
            if (acc) xi++;
            exp_w = (n < 8) ? w_word(n) : x_word(n - 8);
            check($sformatf("drain_valid_%0d", n), 32'(issue_valid), 1);
            check($sformatf("drain_fields_%0d", n), 32'(fields()), 32'(exp_w));
            if (n == 0) check("drain_count_first", 32'(count), 7);
            if (n == 3) check("drain_count_steady", 32'(count), 7);
        end
        check("drain_pushed_all", 32'(xi), 6);
        check("drain_count_empty", 32'(count), 0);

        // Flush with a pending hazard and a simultaneous push.
        in_valid = 1'b1; issue_en = 1'b0;
        in_instr = P;
        tick();
        for (int k = 0; k < 5; k++) begin
            in_instr = {4'h4, 4'h5, 4'h2, 4'h6, 8'(8'h20 + k)};
            tick();
        end
        check("flush_pre_count", 32'(count), 6);
        in_valid = 1'b0; issue_en = 1'b1;
        tick();
        check("flush_p_issue", 32'(fields()), 32'(P));
        check("flush_pre_count5", 32'(count), 5);
        check("flush_hazard_stall", 32'(stall), 1);
        flush = 1'b1; in_valid = 1'b1; in_instr = Z;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_count", 32'(count), 0);
        check("flush_issue_valid", 32'(issue_valid), 0);
        check("flush_fields_hold", 32'(fields()), 32'(P));
        check("flush_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1; in_instr = D;
        tick();
        in_valid = 1'b0;
        check("post_flush_count", 32'(count), 1);
        check("post_flush_stall", 32'(stall), 0);
        tick();
        check("post_flush_issue", 32'(issue_valid), 1);
        check("post_flush_fields", 32'(fields()), 32'(D));

        // Asynchronous reset mid-stream.
        issue_en = 1'b0; in_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_instr = x_word(j);
            tick();
        end
        in_valid = 1'b0;
        check("areset_pre_count", 32'(count), 4);
        #3 rst_n = 1'b0;
        #1;
        check("areset_count", 32'(count), 0);
        check("areset_issue_valid", 32'(issue_valid), 0);
        check("areset_fields", 32'(fields()), 0);
        check("areset_in_ready", 32'(in_ready), 1);
        #1 rst_n = 1'b1;
        issue_en = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check($sformatf("areset_no_stale_%0d", j), 32'(issue_valid), 0);
        end
        check("areset_final_count", 32'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
